// File: rtl/lcd_spi_seq.sv
// LCD SPI sequencer: runs the LCD reset pulse and ROM init script, then forwards host bytes to the SPI master.
// Optional LCD_SPI_TIMEOUT_EN bounds the spi_done wait and raises a sticky err.
module lcd_spi_seq #(
  parameter int INIT_LEN   = 8,
  parameter int RST_CYCLES = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_init,
  output logic [$clog2(INIT_LEN)-1:0] rom_addr,
  input  logic [9:0]                  rom_word,
  input  logic                        host_valid,
  input  logic                        host_dc,
  input  logic [7:0]                  host_byte,
  output logic                        host_ready,
  output logic                        spi_send,
  output logic [7:0]                  spi_data,
  input  logic                        spi_done,
  output logic                        lcd_dc,
  output logic                        lcd_rst_n,
  output logic                        init_done,
  output logic                        busy,
  output logic                        err
);
  localparam int AW    = $clog2(INIT_LEN);
  localparam int W_RST = $clog2(RST_CYCLES + 1);
  localparam int W_TO  = $clog2(TIMEOUT + 1);
  localparam int CW0   = (W_RST > W_TO) ? W_RST : W_TO;
  localparam int CW    = (CW0 > 12) ? CW0 : 12;
  localparam logic [AW-1:0] LAST_ADDR = AW'(INIT_LEN - 1);
  localparam logic [CW-1:0] RST_LOAD  = CW'(RST_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, RST_LO, RST_WT, FETCH, SEND, WAIT_LO, WAIT_HI, DELAY, NEXT, READY
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      data_d;
  logic            dc_d, rst_n_d, done_d, host_src_q, host_src_d, err_q, err_d;
  logic [AW-1:0]   addr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      spi_data   <= '0;
      lcd_dc     <= 1'b0;
      lcd_rst_n  <= 1'b1;
      rom_addr   <= '0;
      init_done  <= 1'b0;
      host_src_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      spi_data   <= data_d;
      lcd_dc     <= dc_d;
      lcd_rst_n  <= rst_n_d;
      rom_addr   <= addr_d;
      init_done  <= done_d;
      host_src_q <= host_src_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = spi_data;
    dc_d       = lcd_dc;
    rst_n_d    = lcd_rst_n;
    addr_d     = rom_addr;
    done_d     = init_done;
    host_src_d = host_src_q;
    err_d      = err_q;
    case (state_q)
      IDLE, READY: begin
        if (start_init) begin
          state_d = RST_LO;
          rst_n_d = 1'b0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          cnt_d   = RST_LOAD;
        end else if (state_q == READY && host_valid) begin
          state_d    = SEND;
          data_d     = host_byte;
          dc_d       = host_dc;
          host_src_d = 1'b1;
        end
      end
      RST_LO: begin
        if (cnt_q == '0) begin
          state_d = RST_WT;
          rst_n_d = 1'b1;
          cnt_d   = RST_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RST_WT: begin
        if (cnt_q == '0) begin
          state_d = FETCH;
          addr_d  = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FETCH: begin
        host_src_d = 1'b0;
        case (rom_word[9:8])
          2'b10: begin
            state_d = DELAY;
            cnt_d   = CW'({rom_word[7:0], 4'h0});
          end
          2'b11: begin
            state_d = READY;
            done_d  = 1'b1;
          end
          default: begin
            state_d = SEND;
            data_d  = rom_word[7:0];
            dc_d    = rom_word[8];
          end
        endcase
      end
      // Skip WAIT_LO when done is already low so the wait adds no latency.
      SEND:    state_d = spi_done ? WAIT_LO : WAIT_HI;
      WAIT_LO: if (!spi_done) state_d = WAIT_HI;
      WAIT_HI: if (spi_done) state_d = host_src_q ? READY : NEXT;
      DELAY: begin
        if (cnt_q <= CW'(1)) state_d = NEXT;
        else                 cnt_d   = cnt_q - 1'b1;
      end
      NEXT: begin
        if (rom_addr == LAST_ADDR) begin
          state_d = READY;
          done_d  = 1'b1;
        end else begin
          state_d = FETCH;
          addr_d  = rom_addr + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef LCD_SPI_TIMEOUT_EN
    // The shared counter is idle during the WAIT states, so it doubles as the timeout counter.
    if (state_d == SEND) begin
      cnt_d = '0;
    end else if ((state_q == WAIT_LO || state_q == WAIT_HI) &&
                 (state_d == WAIT_LO || state_d == WAIT_HI)) begin
      if (cnt_q == CW'(TIMEOUT - 1)) begin
        state_d = IDLE;
        err_d   = 1'b1;
        done_d  = 1'b0;
        dc_d    = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  assign spi_send   = (state_q == SEND);
  assign host_ready = (state_q == READY);
  assign busy       = (state_q != IDLE) && (state_q != READY);
  assign err        = err_q;

endmodule

// File: tb/tb_lcd_spi_seq.sv
// Bench for lcd_spi_seq: timeline model built from the init script and master latencies, checked every cycle.
`timescale 1ns/1ps
module tb_lcd_spi_seq;
  localparam int N  = 4;
  localparam int R  = 4;
  localparam int TO = 64;

  logic       clk = 1'b0, rst = 1'b1, start_init = 1'b0;
  logic       host_valid = 1'b0, host_dc = 1'b0, spi_done;
  logic [7:0] host_byte = '0, spi_data;
  logic [1:0] rom_addr;
  logic [9:0] rom_word;
  logic       host_ready, spi_send, lcd_dc, lcd_rst_n, init_done, busy, err;
  logic [9:0] rom [N];

  assign rom_word = rom[rom_addr];
  always #5 clk = ~clk;

  lcd_spi_seq #(.INIT_LEN(N), .RST_CYCLES(R), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start_init(start_init), .rom_addr(rom_addr), .rom_word(rom_word),
    .host_valid(host_valid), .host_dc(host_dc), .host_byte(host_byte), .host_ready(host_ready),
    .spi_send(spi_send), .spi_data(spi_data), .spi_done(spi_done), .lcd_dc(lcd_dc),
    .lcd_rst_n(lcd_rst_n), .init_done(init_done), .busy(busy), .err(err)
  );

  // Expected outputs as a list of constant-valued segments; len 0 = holds until the bench acts.
  typedef struct {
    int         len;
    bit         send, rst_n, bsy, hrdy, idone, er, dc;
    logic [7:0] data;
    logic [1:0] addr;
  } seg_t;

  seg_t       q[$];
  int         lat_q[$];
  logic [7:0] m_data;
  logic [1:0] m_addr;
  bit         m_dc, m_idone, m_err, cur_idle, hr_prev, stuck;
  int         total = 0, bad = 0, cyc = 0, fixed_lat = 0, mcnt = 0, t0 = 0, ts = 0;
  int         send_cyc[$], rst_lo_n = 0, ready_cyc = 0;
  logic [8:0] send_dat[$];
  seg_t       cs;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void push(input int len, input bit snd, input bit rn, input bit b, input bit hr);
    seg_t s;
    s.len = len; s.send = snd; s.rst_n = rn; s.bsy = b; s.hrdy = hr;
    s.idone = m_idone; s.er = m_err; s.dc = m_dc; s.data = m_data; s.addr = m_addr;
    q.push_back(s);
  endfunction

  // One byte: SEND cycle, then done low for l cycles plus the cycle that sees it high.
  function automatic void xfer();
    int l;
    l = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6));
    lat_q.push_back(l);
    push(1, 1, 1, 1, 0);
    push(l + 1, 0, 1, 1, 0);
  endfunction

  function automatic void build_init();
    logic [1:0] k;
    logic [7:0] v;
    q.delete();
    m_idone = 0; m_err = 0;
    push(R, 0, 0, 1, 0);
    push(R, 0, 1, 1, 0);
    m_addr = '0;
    for (int i = 0; i < N; i++) begin
      m_addr = 2'(i);
      k = rom[i][9:8];
      v = rom[i][7:0];
      push(1, 0, 1, 1, 0);
      if (k == 2'b11) break;
      if (!k[1]) begin
        m_data = v; m_dc = k[0];
        xfer();
      end else begin
        push((v == 0) ? 1 : int'(v) * 16, 0, 1, 1, 0);
      end
      push(1, 0, 1, 1, 0);
    end
    m_idone = 1;
    push(0, 0, 1, 0, 1);
  endfunction

  function automatic void build_host(input logic [7:0] b, input bit d);
    q.delete();
    m_data = b; m_dc = d;
    xfer();
    push(0, 0, 1, 0, 1);
  endfunction

  function automatic void reset_model();
    q.delete(); lat_q.delete();
    m_data = '0; m_dc = 0; m_addr = '0; m_idone = 0; m_err = 0;
    push(0, 0, 1, 0, 0);
  endfunction

  function automatic int next_lat();
    if (lat_q.size() > 0) return lat_q.pop_front();
    return 3;
  endfunction

  // SPI master stand-in: done drops after a send and rises after the queued latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      spi_done <= 1'b0;
      mcnt     <= 0;
    end else if (stuck) begin
      spi_done <= 1'b1;
    end else if (spi_send) begin
      spi_done <= 1'b0;
      mcnt     <= next_lat();
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) spi_done <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (q.size() > 0) begin
      cs = q[0];
      chk("spi_send",   spi_send,   cs.send);
      chk("spi_data",   spi_data,   cs.data);
      chk("lcd_dc",     lcd_dc,     cs.dc);
      chk("lcd_rst_n",  lcd_rst_n,  cs.rst_n);
      chk("rom_addr",   rom_addr,   cs.addr);
      chk("init_done",  init_done,  cs.idone);
      chk("host_ready", host_ready, cs.hrdy);
      chk("busy",       busy,       cs.bsy);
      chk("err",        err,        cs.er);
      if (cs.len == 0) begin
        cur_idle = 1;
      end else begin
        cur_idle = 0;
        cs.len = cs.len - 1;
        if (cs.len == 0) q.delete(0);
        else             q[0] = cs;
      end
    end
    if (spi_send) begin
      send_cyc.push_back(cyc);
      send_dat.push_back({lcd_dc, spi_data});
    end
    if (!lcd_rst_n) rst_lo_n++;
    if (host_ready && !hr_prev) ready_cyc = cyc;
    hr_prev = host_ready;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    send_cyc.delete(); send_dat.delete(); rst_lo_n = 0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    tick();
    while (!cur_idle && n < bound) begin
      tick();
      n++;
    end
    chk("idle_reached", cur_idle, 1);
  endtask

  task automatic do_start();
    start_init = 1; build_init(); t0 = cyc;
    tick();
    start_init = 0;
  endtask

  task automatic do_host(input logic [7:0] b, input bit d);
    host_valid = 1; host_byte = b; host_dc = d; build_host(b, d); t0 = cyc;
    tick();
    host_valid = 0;
  endtask

  task automatic noise_while_busy(input int bound);
    int n;
    n = 0;
    while (!cur_idle && n < bound) begin
      host_valid = $urandom_range(0, 1);
      host_dc    = $urandom_range(0, 1);
      host_byte  = 8'($urandom);
      start_init = ($urandom_range(0, 3) == 0);
      tick();
      n++;
    end
    host_valid = 0; start_init = 0;
  endtask

  task automatic rand_rom();
    logic [1:0] k;
    for (int i = 0; i < N; i++) begin
      k = 2'($urandom_range(0, 3));
      rom[i] = {k, (k == 2'b10) ? 8'($urandom_range(0, 3)) : 8'($urandom)};
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    stuck = 0;
    rand_rom();
    rst = 1;
    reset_model();
    repeat (3) tick();
    rst = 0;
    repeat (5) begin
      host_valid = $urandom_range(0, 1);
      host_byte  = 8'($urandom);
      tick();
    end
    host_valid = 0;

    // Reset pulse, command, 32-cycle delay, data, end.
    rom[0] = 10'h011; rom[1] = 10'h202; rom[2] = 10'h1AB; rom[3] = 10'h300;
    fixed_lat = 3;
    clear_mon();
    do_start(); ts = t0;
    wait_idle(500);
    chk("t2_rst_lo_cycles", rst_lo_n, 4);
    chk("t2_nsend", send_cyc.size(), 2);
    if (send_cyc.size() >= 2) begin
      chk("t2_first_send_lat", send_cyc[0] - ts, 10);
      chk("t2_byte0", send_dat[0], 9'h011);
      chk("t2_send_gap", send_cyc[1] - send_cyc[0], 41);
      chk("t2_byte1", send_dat[1], 9'h1AB);
      chk("t2_ready_lat", ready_cyc - send_cyc[1], 7);
    end

    fixed_lat = 2;
    clear_mon();
    do_host(8'h5A, 1'b1); ts = t0;
    chk("t3_hready_low", host_ready, 0);
    wait_idle(100);
    chk("t3_nsend", send_cyc.size(), 1);
    if (send_cyc.size() >= 1) begin
      chk("t3_send_lat", send_cyc[0] - ts, 1);
      chk("t3_byte", send_dat[0], 9'h15A);
      chk("t3_ready_lat", ready_cyc - send_cyc[0], 4);
    end

    fixed_lat = 0;
    repeat (20) begin
      repeat ($urandom_range(0, 3)) tick();
      do_host(8'($urandom), 1'($urandom));
      wait_idle(100);
    end

    do_start();
    noise_while_busy(3000);
    wait_idle(3000);
    clear_mon();
    start_init = 1; host_valid = 1; host_byte = 8'hE7; build_init();
    tick();
    start_init = 0; host_valid = 0;
    chk("t4_rst_n_low", lcd_rst_n, 0);
    chk("t4_no_send", send_cyc.size(), 0);
    wait_idle(3000);

    rom[0] = 10'h011; rom[1] = 10'h012; rom[2] = 10'h013; rom[3] = 10'h014;
    clear_mon();
    do_start();
    wait_idle(500);
    chk("t5_nsend", send_cyc.size(), 4);
    chk("t5_addr_last", rom_addr, 2'd3);
    do_host(8'h99, 1'b0);
    wait_idle(100);
    chk("t5_addr_hold", rom_addr, 2'd3);

    repeat (6) begin
      rand_rom();
      do_start();
      noise_while_busy(3000);
      wait_idle(3000);
      repeat ($urandom_range(1, 4)) begin
        do_host(8'($urandom), 1'($urandom));
        wait_idle(100);
      end
    end

    do_host(8'h3C, 1'b1);
    repeat (2) tick();
    rst = 1;
    reset_model();
    repeat (2) tick();
    rst = 0;
    tick();
    rand_rom();
    do_start();
    wait_idle(3000);

`ifdef LCD_SPI_TIMEOUT_EN
    stuck = 1;
    host_valid = 1; host_byte = 8'hC3; host_dc = 1;
    q.delete();
    m_data = 8'hC3; m_dc = 1;
    push(1, 1, 1, 1, 0);
    push(TO, 0, 1, 1, 0);
    m_err = 1; m_idone = 0; m_dc = 0;
    push(0, 0, 1, 0, 0);
    tick();
    host_valid = 0;
    wait_idle(200);
    chk("t6_err_set", err, 1);
    chk("t6_init_done_low", init_done, 0);
    stuck = 0;
    do_start();
    chk("t6_err_cleared", err, 0);
    wait_idle(3000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
